// File: rtl/bh_run_ctrl_pkg.sv
// bh_run_ctrl_pkg: command, state, status and tape-owner encodings for the run controller
package bh_run_ctrl_pkg;

  typedef enum logic [1:0] {CMD_NOP, CMD_LOAD, CMD_RUN, CMD_DUMP} cmd_e;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DUMP} state_e;

  typedef enum logic [1:0] {ST_NONE, ST_EOP, ST_ABORT, ST_LIMIT} status_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_CLEAR, OWN_CORE, OWN_DUMP} owner_e;

  // abort outranks end-of-program, which outranks the cycle limit
  function automatic status_e run_end_status(input logic abort, input logic eop);
    return abort ? ST_ABORT : eop ? ST_EOP : ST_LIMIT;
  endfunction

endpackage

// File: rtl/bh_tape_mux.sv
// bh_tape_mux: selects which agent drives the tape write/address port
module bh_tape_mux
  import bh_run_ctrl_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  owner_e          i_owner,
  input  logic [AW-1:0]   i_clear_addr,
  input  logic            i_core_we,
  input  logic [AW-1:0]   i_core_addr,
  input  logic [DW-1:0]   i_core_data,
  input  logic [AW-1:0]   i_dump_addr,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_wdata
);

  // clear writes zeros everywhere, core writes its own data, dump only reads
  always_comb begin
    o_we    = (i_owner == OWN_CLEAR) || ((i_owner == OWN_CORE) && i_core_we);
    o_addr  = (i_owner == OWN_CLEAR) ? i_clear_addr :
              (i_owner == OWN_CORE)  ? i_core_addr  :
              (i_owner == OWN_DUMP)  ? i_dump_addr  : '0;
    o_wdata = (i_owner == OWN_CORE) ? i_core_data : '0;
  end

endmodule

// File: rtl/bh_run_ctrl.sv
// bh_run_ctrl: host-side load / clear / run / dump controller for the brainhack core
module bh_run_ctrl
  import bh_run_ctrl_pkg::*;
#(
  parameter int PRG_ADDR_W  = 8,
  parameter int TAPE_ADDR_W = 8,
  parameter int TAPE_DATA_W = 8,
  parameter int INSTR_W     = 3,
  parameter int CYC_W       = 24
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic [PRG_ADDR_W-1:0]  i_cmd_arg,
  output logic                   o_cmd_ready,
  input  logic                   i_host_valid,
  input  logic [7:0]             i_host_data,
  output logic                   o_host_ready,
  output logic                   o_out_valid,
  output logic [TAPE_DATA_W-1:0] o_out_data,
  input  logic                   i_out_ready,
  input  logic                   i_abort,
  output logic                   o_prgmem_we,
  output logic [PRG_ADDR_W-1:0]  o_prgmem_waddr,
  output logic [INSTR_W-1:0]     o_prgmem_wdata,
  input  logic [PRG_ADDR_W-1:0]  i_core_pc,
  output logic                   o_core_run,
  output logic                   o_core_rst,
  input  logic                   i_core_tape_we,
  input  logic [TAPE_ADDR_W-1:0] i_core_tape_addr,
  input  logic [TAPE_DATA_W-1:0] i_core_tape_data,
  output logic                   o_tape_we,
  output logic [TAPE_ADDR_W-1:0] o_tape_addr,
  output logic [TAPE_DATA_W-1:0] o_tape_wdata,
  input  logic [TAPE_DATA_W-1:0] i_tape_rdata,
  output logic                   o_done,
  output logic [1:0]             o_status,
  output logic [CYC_W-1:0]       o_cycles
);

  state_e                 state, state_n;
  owner_e                 owner;
  status_e                status;
  cmd_e                   cmd;
  logic [PRG_ADDR_W-1:0]  prg_len, waddr;
  logic [TAPE_ADDR_W-1:0] clr_addr, dump_addr, dump_end;
  logic                   cmd_go, load_empty, load_last, load_take;
  logic                   eop, lim, run_exit, dump_take;
  logic                   unused_hi;

  assign cmd        = cmd_e'(i_cmd);
  assign cmd_go     = i_cmd_valid && (state == S_IDLE);
  assign load_empty = waddr == prg_len;
  assign load_last  = (waddr + PRG_ADDR_W'(1)) == prg_len;
  assign load_take  = (state == S_LOAD) && i_host_valid && !load_empty;
  assign eop        = i_core_pc == prg_len;
  assign lim        = &o_cycles;
  assign run_exit   = (state == S_RUN) && (i_abort || eop || lim);
  assign dump_take  = (state == S_DUMP) && i_out_ready;
  assign unused_hi  = ^i_host_data[7:INSTR_W];

  assign o_cmd_ready    = state == S_IDLE;
  assign o_host_ready   = (state == S_LOAD) && !load_empty;
  assign o_prgmem_we    = load_take;
  assign o_prgmem_waddr = waddr;
  assign o_prgmem_wdata = i_host_data[INSTR_W-1:0];
  assign o_out_data     = (state == S_DUMP) ? i_tape_rdata : '0;
  assign o_status       = status;

  bh_tape_mux #(.AW(TAPE_ADDR_W), .DW(TAPE_DATA_W)) u_tape_mux (
    .i_owner      (owner),
    .i_clear_addr (clr_addr),
    .i_core_we    (i_core_tape_we && o_core_run),
    .i_core_addr  (i_core_tape_addr),
    .i_core_data  (i_core_tape_data),
    .i_dump_addr  (dump_addr),
    .o_we         (o_tape_we),
    .o_addr       (o_tape_addr),
    .o_wdata      (o_tape_wdata)
  );

  // state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_n;
  end

  // next state, tape ownership and core control
  always_comb begin
    state_n     = state;
    owner       = OWN_NONE;
    o_core_run  = 1'b0;
    o_core_rst  = 1'b0;
    o_out_valid = 1'b0;
    case (state)
      S_IDLE:  if (cmd_go) state_n = (cmd == CMD_LOAD) ? S_LOAD :
                                     (cmd == CMD_RUN)  ? S_CLEAR :
                                     (cmd == CMD_DUMP) ? S_DUMP : S_IDLE;
      S_LOAD:  if (i_abort || load_empty || (load_take && load_last)) state_n = S_IDLE;
      S_CLEAR: begin
        owner      = OWN_CLEAR;
        o_core_rst = 1'b1;
        state_n    = i_abort ? S_IDLE : (&clr_addr) ? S_RUN : S_CLEAR;
      end
      S_RUN: begin
        owner      = OWN_CORE;
        o_core_run = !run_exit;
        if (run_exit) state_n = S_IDLE;
      end
      S_DUMP: begin
        owner       = OWN_DUMP;
        o_out_valid = 1'b1;
        if (i_abort || (dump_take && (dump_addr == dump_end))) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // run completion pulse and sticky end status
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_done <= 1'b0;
      status <= ST_NONE;
    end else begin
      o_done <= run_exit;
      if (run_exit) status <= run_end_status(i_abort, eop);
    end
  end

  // program length and load write address
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prg_len <= '0;
      waddr   <= '0;
    end else if (cmd_go && (cmd == CMD_LOAD)) begin
      prg_len <= i_cmd_arg;
      waddr   <= '0;
    end else if (load_take) begin
      waddr   <= waddr + PRG_ADDR_W'(1);
    end
  end

  // tape clear sweep address and run-cycle counter
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      clr_addr <= '0;
      o_cycles <= '0;
    end else if (cmd_go && (cmd == CMD_RUN)) begin
      clr_addr <= '0;
      o_cycles <= '0;
    end else begin
      if (state == S_CLEAR) clr_addr <= clr_addr + TAPE_ADDR_W'(1);
      if (o_core_run)       o_cycles <= o_cycles + CYC_W'(1);
    end
  end

  // dump read address and last-cell index
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dump_addr <= '0;
      dump_end  <= '0;
    end else if (cmd_go && (cmd == CMD_DUMP)) begin
      dump_addr <= '0;
      dump_end  <= TAPE_ADDR_W'(i_cmd_arg);
    end else if (dump_take) begin
      dump_addr <= dump_addr + TAPE_ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_bh_run_ctrl.sv
// tb_bh_run_ctrl: self-checking bench with core/memory models and a program-level reference
`timescale 1ns/1ps
module tb_bh_run_ctrl;
  import bh_run_ctrl_pkg::*;

  localparam int PW = 8, AW = 8, DW = 8, IW = 3, CW = 4;

  logic          i_clock, i_reset_n;
  logic          i_cmd_valid, i_host_valid, i_out_ready, i_abort;
  logic [1:0]    i_cmd;
  logic [PW-1:0] i_cmd_arg;
  logic [7:0]    i_host_data;
  logic          o_cmd_ready, o_host_ready, o_out_valid, o_prgmem_we;
  logic [DW-1:0] o_out_data;
  logic [PW-1:0] o_prgmem_waddr;
  logic [IW-1:0] o_prgmem_wdata;
  logic          o_core_run, o_core_rst, o_tape_we, o_done;
  logic [AW-1:0] o_tape_addr;
  logic [DW-1:0] o_tape_wdata, i_tape_rdata;
  logic [1:0]    o_status;
  logic [CW-1:0] o_cycles;
  logic          core_we;
  logic [DW-1:0] core_data;
  logic [IW-1:0] cur;
  logic [7:0]    core_pc = '0, ptr = '0;

  logic [IW-1:0] prog_mem [256];
  logic [DW-1:0] tape     [256];
  logic [IW-1:0] ref_prog [256];
  logic [DW-1:0] ref_tape [256];
  int            ref_steps, ref_stat;
  int            done_cnt = 0, clr_cnt = 0;
  int            checks = 0, errors = 0;

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic [7:0] a;
    logic       cr, hr, rst, ov;
  } vec_t;
  vec_t vt [6];

  bh_run_ctrl #(.PRG_ADDR_W(PW), .TAPE_ADDR_W(AW), .TAPE_DATA_W(DW), .INSTR_W(IW), .CYC_W(CW)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .o_cmd_ready(o_cmd_ready),
    .i_host_valid(i_host_valid), .i_host_data(i_host_data), .o_host_ready(o_host_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .i_abort(i_abort),
    .o_prgmem_we(o_prgmem_we), .o_prgmem_waddr(o_prgmem_waddr), .o_prgmem_wdata(o_prgmem_wdata),
    .i_core_pc(core_pc), .o_core_run(o_core_run), .o_core_rst(o_core_rst),
    .i_core_tape_we(core_we), .i_core_tape_addr(ptr), .i_core_tape_data(core_data),
    .o_tape_we(o_tape_we), .o_tape_addr(o_tape_addr), .o_tape_wdata(o_tape_wdata),
    .i_tape_rdata(i_tape_rdata),
    .o_done(o_done), .o_status(o_status), .o_cycles(o_cycles)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // next pc for brainhack ops: 0 '>' 1 '<' 2 '+' 3 '-' 6 '[' 7 ']', others fall through
  function automatic int jump(input logic [2:0] p [256], input int pc, input bit zero);
    int r = pc + 1, d = 0;
    bit f = 0;
    if (p[pc] == 3'd6 && zero)
      for (int i = pc; i < 256; i++)
        if (!f) begin
          if (p[i] == 3'd6) d++;
          if (p[i] == 3'd7) d--;
          if (d == 0) begin r = i + 1; f = 1; end
        end
    if (p[pc] == 3'd7 && !zero)
      for (int i = pc; i >= 0; i--)
        if (!f) begin
          if (p[i] == 3'd7) d++;
          if (p[i] == 3'd6) d--;
          if (d == 0) begin r = i + 1; f = 1; end
        end
    return r;
  endfunction

  assign cur          = prog_mem[core_pc];
  assign core_we      = (cur == 3'd2) || (cur == 3'd3);
  assign core_data    = (cur == 3'd2) ? tape[ptr] + 8'd1 : tape[ptr] - 8'd1;
  assign i_tape_rdata = tape[o_tape_addr];

  always @(posedge i_clock) begin
    if (o_tape_we)   tape[o_tape_addr]        <= o_tape_wdata;
    if (o_prgmem_we) prog_mem[o_prgmem_waddr] <= o_prgmem_wdata;
    if (o_core_rst) begin
      core_pc <= '0;
      ptr     <= '0;
    end else if (o_core_run) begin
      if (cur == 3'd0) ptr <= ptr + 8'd1;
      else if (cur == 3'd1) ptr <= ptr - 8'd1;
      core_pc <= 8'(jump(prog_mem, int'(core_pc), tape[ptr] == 8'd0));
    end
  end

  always @(negedge i_clock) begin
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_tape_we && o_core_rst) clr_cnt <= clr_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] a);
    i_cmd_valid = 1'b1; i_cmd = c; i_cmd_arg = a;
    tick;
    i_cmd_valid = 1'b0;
  endtask

  // whole-program interpretation on a freshly cleared tape, capped at the cycle limit
  task automatic ref_run(input int len);
    int pc = 0, p = 0;
    bit z;
    for (int i = 0; i < 256; i++) ref_tape[i] = '0;
    ref_steps = 0;
    while (pc != len && ref_steps < (1 << CW) - 1) begin
      z = ref_tape[p] == 0;
      case (ref_prog[pc])
        3'd0: p = (p + 1) % 256;
        3'd1: p = (p + 255) % 256;
        3'd2: ref_tape[p] = ref_tape[p] + 8'd1;
        3'd3: ref_tape[p] = ref_tape[p] - 8'd1;
        default: ;
      endcase
      pc = jump(ref_prog, pc, z);
      ref_steps++;
    end
    ref_stat = (pc == len) ? 1 : 3;
  endtask

  task automatic load_prog(input int len, input bit rnd_hi);
    int bad = 0;
    issue(2'd1, 8'(len));
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      i_host_valid = 1'b1;
      i_host_data  = {rnd_hi ? 5'($urandom) : 5'd0, ref_prog[i]};
      #1;
      chk("load_we", o_prgmem_we, 1);
      chk("load_addr", o_prgmem_waddr, i);
      tick;
      i_host_valid = 1'b0;
    end
    if (len == 0) tick;
    chk("load_idle", o_cmd_ready, 1);
    for (int i = 0; i < len; i++) if (prog_mem[i] !== ref_prog[i]) bad++;
    chk("load_mem", bad, 0);
  endtask

  task automatic run_chk(input int len);
    int d0 = done_cnt, c0 = clr_cnt, bad = 0;
    ref_run(len);
    issue(2'd2, 8'd0);
    for (int k = 0; k < 700 && !o_done; k++) tick;
    chk("run_done", o_done, 1);
    chk("run_status", o_status, ref_stat);
    chk("run_cycles", o_cycles, ref_steps);
    chk("run_core_off", o_core_run, 0);
    chk("run_idle", o_cmd_ready, 1);
    tick;
    tick;
    chk("run_done_once", done_cnt - d0, 1);
    chk("run_clear_writes", clr_cnt - c0, 256);
    for (int i = 0; i < 256; i++) if (tape[i] !== ref_tape[i]) bad++;
    chk("run_tape", bad, 0);
  endtask

  task automatic dump_chk(input int arg);
    int idx = 0, g = 0;
    issue(2'd3, 8'(arg));
    while (idx <= arg && g < 2000) begin
      i_out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("dump_valid", o_out_valid, 1);
      chk("dump_data", o_out_data, ref_tape[idx]);
      tick;
      if (i_out_ready) idx++;
      g++;
    end
    i_out_ready = 1'b0;
    chk("dump_count", idx, arg + 1);
    chk("dump_idle", o_cmd_ready, 1);
  endtask

  initial begin
    vt[0] = '{1'b1, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 2'd1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 2'd1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 2'd2, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 2'd3, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd = '0; i_cmd_arg = '0;
    i_host_valid = 1'b0; i_host_data = '0; i_out_ready = 1'b0; i_abort = 1'b0;
    #12;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_quiet", {o_host_ready, o_prgmem_we, o_out_valid, o_core_run, o_core_rst, o_tape_we, o_done}, 0);
    chk("rst_regs", {o_status, o_cycles, o_prgmem_waddr, o_tape_addr, o_out_data}, 0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    tick;

    for (int r = 0; r < 6; r++) begin
      i_cmd_valid = vt[r].v; i_cmd = vt[r].c; i_cmd_arg = vt[r].a;
      tick;
      i_cmd_valid = 1'b0;
      chk($sformatf("tbl%0d_state", r), {o_cmd_ready, o_host_ready, o_core_rst, o_out_valid},
          {vt[r].cr, vt[r].hr, vt[r].rst, vt[r].ov});
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      chk($sformatf("tbl%0d_abort", r), o_cmd_ready, 1);
      chk($sformatf("tbl%0d_stat", r), {o_done, o_status}, 0);
    end

    issue(2'd1, 8'd4);
    i_host_valid = 1'b1; i_host_data = 8'h05;
    #1 chk("midload_we", o_prgmem_we, 1);
    i_reset_n = 1'b0;
    #1;
    chk("midload_rst", {o_cmd_ready, o_host_ready, o_prgmem_we}, 3'b100);
    i_host_valid = 1'b0;
    tick;
    i_reset_n = 1'b1;
    tick;

    ref_prog[0] = 3'd2; ref_prog[1] = 3'd4; ref_prog[2] = 3'd6;
    load_prog(3, 1'b0);

    ref_prog[0] = 3'd2; ref_prog[1] = 3'd2; ref_prog[2] = 3'd2;
    load_prog(3, 1'b0);
    run_chk(3);
    chk("plus3_cell0", tape[0], 3);
    chk("plus3_cycles", o_cycles, 3);

    load_prog(0, 1'b0);
    run_chk(0);

    ref_prog[0] = 3'd2; ref_prog[1] = 3'd6; ref_prog[2] = 3'd7;
    load_prog(3, 1'b0);
    run_chk(3);
    chk("limit_status", o_status, 3);

    ref_prog[0] = 3'd2;
    load_prog(1, 1'b0);
    issue(2'd2, 8'd0);
    for (int k = 0; k < 400 && !o_core_run; k++) tick;
    chk("abort_running", o_core_run, 1);
    tick;
    chk("abort_eop_halt", o_core_run, 0);
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("abort_done", o_done, 1);
    chk("abort_status", o_status, 2);
    chk("abort_cycles", o_cycles, 1);

    ref_prog[0] = 3'd2; ref_prog[1] = 3'd2; ref_prog[2] = 3'd2;
    ref_prog[3] = 3'd0; ref_prog[4] = 3'd2; ref_prog[5] = 3'd2;
    load_prog(6, 1'b1);
    run_chk(6);
    issue(2'd3, 8'd1);
    i_out_ready = 1'b0;
    #1 chk("stall_w0a", {o_out_valid, o_out_data}, {1'b1, 8'd3});
    tick;
    #1 chk("stall_w0b", {o_out_valid, o_out_data}, {1'b1, 8'd3});
    tick;
    i_out_ready = 1'b1;
    #1 chk("stall_w0c", {o_out_valid, o_out_data}, {1'b1, 8'd3});
    tick;
    #1 chk("stall_w1", {o_out_valid, o_out_data}, {1'b1, 8'd2});
    tick;
    i_out_ready = 1'b0;
    chk("stall_end", {o_cmd_ready, o_out_valid}, 2'b10);

    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) ref_prog[i] = 3'($urandom_range(0, 5));
      load_prog(len, 1'b1);
      run_chk(len);
      dump_chk($urandom_range(0, 15));
    end
    dump_chk(255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
